rt_dyn_pri_tmr_fsm: RTL and testbench

- Multi-channel successor to the single-channel dynamic-priority FSM.
- Each of NUM_CH channels runs a hysteresis FSM:
  - acq_thresh_hi raises priority.
  - acq_thresh_lo drops it.
  - A programmable minimum dwell applies between changes.
- State and dwell counters are triple-redundant, majority-voted and scrubbed every cycle.
- Sits between the acquisition-threshold comparators and the arbiter priority inputs; radiation-tolerant variant.

---
 rtl/rt_dyn_pri_tmr_fsm.sv | 131 +++++++++++++
 tb/tb_rt_dyn_pri_tmr_fsm.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/rt_dyn_pri_tmr_fsm.sv
// rt_dyn_pri_tmr_fsm -- multi-channel, radiation-tolerant dynamic-priority FSM.
//
// Each channel is a two-state (LOW/HIGH) hysteresis FSM with a minimum dwell
// between transitions. The state bit and the 4-bit dwell counter are held in
// three copies (A/B/C). A bitwise 2-of-3 vote drives the next-state logic and
// the outputs. All copies reload the voted next value every cycle, so a single
// upset is scrubbed on the following edge.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   acq_thresh_hi  [NUM_CH] high-threshold crossing (raises priority)
//   acq_thresh_lo  [NUM_CH] low-threshold crossing (drops priority)
//   err_clr        synchronous clear of tmr_err; a new set wins over the clear
//   fi_flip        [NUM_CH] fault injection on state copy A (RT_DYN_PRI_FI_EN only)
//   dyn_pri        [NUM_CH] voted priority state, 1 = HIGH
//   dyn_update     [NUM_CH] one-cycle pulse, aligned with the dyn_pri change
//   tmr_err        [NUM_CH] sticky copy-mismatch flag
//
// Optional feature macro: RT_DYN_PRI_FI_EN (adds fi_flip).

module rt_dyn_pri_ch #(
  parameter int unsigned MIN_DWELL = 3,
  parameter int unsigned UPD_BOTH  = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic hi_i,
  input  logic lo_i,
  input  logic err_clr_i,
`ifdef RT_DYN_PRI_FI_EN
  input  logic flip_i,
`endif
  output logic pri_o,
  output logic upd_o,
  output logic err_o
);
  localparam logic [3:0] DWELL = 4'(MIN_DWELL);

  // Index 0 = copy A, 1 = copy B, 2 = copy C.
  logic [2:0]      st_q;
  logic [2:0][3:0] cnt_q;
  logic            upd_q, err_q;

  logic       st_v, st_d, st_a_d, go, dwell_ok, upd_d, err_d, mism;
  logic [3:0] cnt_v, cnt_d;

  assign st_v  = (st_q[0] & st_q[1]) | (st_q[0] & st_q[2]) | (st_q[1] & st_q[2]);
  assign cnt_v = (cnt_q[0] & cnt_q[1]) | (cnt_q[0] & cnt_q[2]) | (cnt_q[1] & cnt_q[2]);

  // Zero dwell: every cycle is eligible; the counter content is irrelevant.
  if (MIN_DWELL == 0) begin : g_nodwell
    assign dwell_ok = 1'b1;
  end else begin : g_dwell
    assign dwell_ok = (cnt_v >= DWELL);
  end

  always_comb begin
    // In LOW only hi matters, in HIGH only lo matters, so hi&lo together toggles.
    go    = dwell_ok & (st_v ? lo_i : hi_i);
    st_d  = st_v ^ go;
    cnt_d = cnt_v;
    if (go)            cnt_d = 4'd0;
    else if (dwell_ok) cnt_d = DWELL;          // saturate, also clamps a corrupted high value
    else               cnt_d = cnt_v + 4'd1;
    upd_d = go & ((UPD_BOTH != 0) | ~st_v);
    mism  = (st_q != {3{st_v}}) | (cnt_q[0] != cnt_v) |
            (cnt_q[1] != cnt_v) | (cnt_q[2] != cnt_v);
    err_d = mism | (err_q & ~err_clr_i);
`ifdef RT_DYN_PRI_FI_EN
    st_a_d = st_d ^ flip_i;
`else
    st_a_d = st_d;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q  <= '0;
      cnt_q <= {3{DWELL}};   // preloaded: first transition after reset is immediate
      upd_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      st_q  <= {st_d, st_d, st_a_d};
      cnt_q <= {3{cnt_d}};
      upd_q <= upd_d;
      err_q <= err_d;
    end
  end

  assign pri_o = st_v;
  assign upd_o = upd_q;
  assign err_o = err_q;
endmodule

module rt_dyn_pri_tmr_fsm #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned MIN_DWELL = 3,
  parameter int unsigned UPD_BOTH  = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] acq_thresh_hi,
  input  logic [NUM_CH-1:0] acq_thresh_lo,
  input  logic              err_clr,
`ifdef RT_DYN_PRI_FI_EN
  input  logic [NUM_CH-1:0] fi_flip,
`endif
  output logic [NUM_CH-1:0] dyn_pri,
  output logic [NUM_CH-1:0] dyn_update,
  output logic [NUM_CH-1:0] tmr_err
);
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    rt_dyn_pri_ch #(
      .MIN_DWELL (MIN_DWELL),
      .UPD_BOTH  (UPD_BOTH)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .hi_i      (acq_thresh_hi[g]),
      .lo_i      (acq_thresh_lo[g]),
      .err_clr_i (err_clr),
`ifdef RT_DYN_PRI_FI_EN
      .flip_i    (fi_flip[g]),
`endif
      .pri_o     (dyn_pri[g]),
      .upd_o     (dyn_update[g]),
      .err_o     (tmr_err[g])
    );
  end
endmodule

// File: tb/tb_rt_dyn_pri_tmr_fsm.sv
// Randomized bench for rt_dyn_pri_tmr_fsm. Three builds run side by side on the
// same stimulus: (dwell 3, rise-only pulse), (dwell 3, both pulses),
// (dwell 0, both pulses). The reference model tracks each channel's priority
// and the time of its last change; a change is allowed once at least
// MIN_DWELL+1 edges have elapsed since the previous one.
module tb_rt_dyn_pri_tmr_fsm;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] hi = '0, lo = '0, fi = '0;
  logic         err_clr = 1'b0;
  logic [N-1:0] pri_o [3];
  logic [N-1:0] upd_o [3];
  logic [N-1:0] err_o [3];

  always #5 clk = ~clk;

  rt_dyn_pri_tmr_fsm #(.NUM_CH(N), .MIN_DWELL(3), .UPD_BOTH(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .acq_thresh_hi(hi), .acq_thresh_lo(lo), .err_clr(err_clr),
`ifdef RT_DYN_PRI_FI_EN
    .fi_flip(fi),
`endif
    .dyn_pri(pri_o[0]), .dyn_update(upd_o[0]), .tmr_err(err_o[0]));

  rt_dyn_pri_tmr_fsm #(.NUM_CH(N), .MIN_DWELL(3), .UPD_BOTH(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .acq_thresh_hi(hi), .acq_thresh_lo(lo), .err_clr(err_clr),
`ifdef RT_DYN_PRI_FI_EN
    .fi_flip(fi),
`endif
    .dyn_pri(pri_o[1]), .dyn_update(upd_o[1]), .tmr_err(err_o[1]));

  rt_dyn_pri_tmr_fsm #(.NUM_CH(N), .MIN_DWELL(0), .UPD_BOTH(1)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .acq_thresh_hi(hi), .acq_thresh_lo(lo), .err_clr(err_clr),
`ifdef RT_DYN_PRI_FI_EN
    .fi_flip(fi),
`endif
    .dyn_pri(pri_o[2]), .dyn_update(upd_o[2]), .tmr_err(err_o[2]));

  int MD [3] = '{3, 3, 0};
  bit UB [3] = '{1'b0, 1'b1, 1'b1};

  bit m_pri  [3][N];
  int m_last [3][N];
  bit m_upd  [3][N];
  bit m_err  [3][N];
  bit m_fpend [N];
  int t = 0;

  int vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [N-1:0] act, input logic [N-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t got %b want %b", tag, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < N; c++) begin
        m_pri[k][c] = 0; m_last[k][c] = -1000; m_upd[k][c] = 0; m_err[k][c] = 0;
      end
    for (int c = 0; c < N; c++) m_fpend[c] = 0;
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] ep, eu, ee;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < N; c++) begin
        ep[c] = m_pri[k][c]; eu[c] = m_upd[k][c]; ee[c] = m_err[k][c];
      end
      chk($sformatf("%s.pri%0d", tag, k), pri_o[k], ep);
      chk($sformatf("%s.upd%0d", tag, k), upd_o[k], eu);
      chk($sformatf("%s.err%0d", tag, k), err_o[k], ee);
    end
  endtask

  // Called at a negedge: drive, take the edge, advance model, check, return at negedge.
  task automatic cycle(input string tag, input logic [N-1:0] h, input logic [N-1:0] l,
                       input logic clr, input logic [N-1:0] f);
    bit want;
    hi = h; lo = l; err_clr = clr;
`ifdef RT_DYN_PRI_FI_EN
    fi = f;
`else
    fi = '0 & f;
`endif
    @(posedge clk);
    t++;
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < N; c++) begin
        want = m_pri[k][c] ? l[c] : h[c];
        m_upd[k][c] = 0;
        if (want && (t - m_last[k][c] >= MD[k] + 1)) begin
          m_upd[k][c]  = UB[k] || !m_pri[k][c];
          m_pri[k][c]  = !m_pri[k][c];
          m_last[k][c] = t;
        end
        // A flipped copy is seen as a mismatch one edge after the flip.
        m_err[k][c] = m_fpend[c] || (m_err[k][c] && !clr);
      end
    for (int c = 0; c < N; c++) m_fpend[c] = fi[c];
    #1 check_all(tag);
    @(negedge clk);
  endtask

  // Entered at a negedge; reset pulse lands mid-cycle, outputs must clear at once.
  task automatic do_reset();
    @(posedge clk);
    t++;
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [N-1:0] h, l, f;
    model_reset();
    #1 check_all("in_rst");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) cycle("idle", '0, '0, 1'b0, '0);

    // ch0: single hi pulse, then lo held: fall allowed 4 edges after the rise.
    cycle("ch0_rise", 4'b0001, '0, 1'b0, '0);
    for (int i = 0; i < 6; i++) cycle("ch0_fall", '0, 4'b0001, 1'b0, '0);

    // ch1: hi and lo held together -> periodic toggling.
    for (int i = 0; i < 14; i++) cycle("ch1_tog", 4'b0010, 4'b0010, 1'b0, '0);
    for (int i = 0; i < 5; i++) cycle("settle", '0, '0, 1'b0, '0);

    // Reset right after a rise (mid-dwell), then an immediate rise afterwards.
    cycle("pre_rst", 4'b1111, '0, 1'b0, '0);
    do_reset();
    cycle("post_rst", 4'b1111, '0, 1'b0, '0);
    cycle("post_rst2", '0, '0, 1'b0, '0);

`ifdef RT_DYN_PRI_FI_EN
    // ch2 HIGH, flip copy A for one cycle: no output change, sticky error until clear.
    cycle("fi_hi", 4'b0100, '0, 1'b0, '0);
    cycle("fi_flip", '0, '0, 1'b0, 4'b0100);
    for (int i = 0; i < 3; i++) cycle("fi_hold", '0, '0, 1'b0, '0);
    cycle("fi_clr", '0, '0, 1'b1, '0);
    cycle("fi_after", '0, '0, 1'b0, '0);
`endif

    // Random phase with occasional clears, flips and mid-run resets.
    for (int i = 0; i < 600; i++) begin
      h = N'($urandom); l = N'($urandom);
      f = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 3) == 0) l = '0;
      if ($urandom_range(0, 59) == 0) do_reset();
      else cycle("rand", h, l, ($urandom_range(0, 9) == 0), f);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
